bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus.sv | 33 +++
 rtl/bus_outstanding_ctr.sv | 50 +++++
 rtl/bus_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/bus.sv
// Shared bus types and arbiter defaults: Wishbone-style request/response structs,
// arbiter state encoding and default sizing.
package bus;

  localparam int unsigned MAX_OUTSTANDING_DEF = 4;
  localparam int unsigned DRAIN_TIMEOUT_DEF   = 15;
  // Wide enough for the largest legal MAX_OUTSTANDING (15).
  localparam int unsigned CNT_W               = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOwn0  = 2'd1,
    StOwn1  = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } m2s_s;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        stall;
    logic [31:0] data;
  } s2m_s;

endpackage

// File: rtl/bus_outstanding_ctr.sv
// Tracks slave requests in flight for the current owner, gates new strobes at the
// limit and filters responses that have no matching request.
module bus_outstanding_ctr
  import bus::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic stb_i,
  input  logic stall_i,
  input  logic rsp_i,
  input  logic clr_i,
  output logic stb_o,
  output logic full_o,
  output logic rsp_o,
  output logic idle_nxt_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count_q, count_d, count_upd;
  logic             inc;

  always_comb begin
    full_o    = (count_q == CntMax);
    stb_o     = stb_i & ~full_o;
    inc       = stb_o & ~stall_i;
    rsp_o     = rsp_i & (count_q != '0);
    count_upd = count_q;
    if (inc && !rsp_o) begin
      count_upd = count_q + CNT_W'(1);
    end else if (!inc && rsp_o) begin
      count_upd = count_q - CNT_W'(1);
    end
    // Reflects this cycle's traffic but not clr_i, so callers may derive clr_i from it.
    idle_nxt_o = (count_upd == '0);
  end

  assign count_d = clr_i ? '0 : count_upd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single slave; ownership is held for
// a whole bus cycle and abandoned cycles are drained before the bus is re-granted.
module bus_arbiter
  import bus::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned DRAIN_TIMEOUT   = DRAIN_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  m2s_s m0_i,
  input  m2s_s m1_i,
  output s2m_s m0_o,
  output s2m_s m1_o,
  output m2s_s s_o,
  input  s2m_s s_i
);

  localparam int unsigned      TmrW    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TmrW-1:0]  TmrLast = TmrW'(DRAIN_TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  logic            prio_q, prio_d;  // 1: master 1 wins the next contention
  logic [TmrW-1:0] tmr_q, tmr_d;

  logic owning;
  m2s_s own_req;
  s2m_s own_rsp;
  logic ctr_stb, ctr_full, ctr_rsp, ctr_idle_nxt, ctr_clr;

  always_comb begin
    owning  = (state_q == StOwn0) || (state_q == StOwn1);
    own_req = (state_q == StOwn1) ? m1_i : m0_i;
  end

  bus_outstanding_ctr #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .stb_i     (owning & own_req.stb),
    .stall_i   (s_i.stall),
    .rsp_i     (s_i.ack | s_i.err),
    .clr_i     (ctr_clr),
    .stb_o     (ctr_stb),
    .full_o    (ctr_full),
    .rsp_o     (ctr_rsp),
    .idle_nxt_o(ctr_idle_nxt)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    tmr_d   = tmr_q;
    ctr_clr = 1'b0;
    case (state_q)
      StIdle: begin
        if (m0_i.cyc && (!m1_i.cyc || !prio_q)) begin
          state_d = StOwn0;
        end else if (m1_i.cyc) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (!own_req.cyc) begin
          prio_d  = (state_q == StOwn0);
          state_d = ctr_idle_nxt ? StIdle : StDrain;
          tmr_d   = '0;
        end
      end
      StDrain: begin
        if (ctr_idle_nxt || (tmr_q == TmrLast)) begin
          state_d = StIdle;
          ctr_clr = 1'b1;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_o           = '0;
    m0_o          = '0;
    m0_o.stall    = 1'b1;
    m1_o          = '0;
    m1_o.stall    = 1'b1;
    own_rsp.ack   = s_i.ack & ctr_rsp;
    own_rsp.err   = s_i.err & ctr_rsp;
    own_rsp.stall = s_i.stall | ctr_full;
    own_rsp.data  = s_i.data;
    if (owning) begin
      s_o     = own_req;
      s_o.stb = ctr_stb;
      if (state_q == StOwn0) begin
        m0_o = own_rsp;
      end else begin
        m1_o = own_rsp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule
